user_wb_arbiter: RTL and testbench

//  Two-master Wishbone arbiter in front of the user_proj_timer slave port in the user area.

---
 rtl/user_wb_pkg.sv | 19 +
 rtl/user_wb_arbiter_if.sv | 41 ++++
 rtl/user_wb_rr_pick.sv | 17 +
 rtl/user_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_user_wb_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/user_wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter in front of
// the user_proj_timer slave.
package user_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int M_MGMT      = 0;
  localparam int M_LA        = 1;
  localparam int DEF_TIMEOUT = 255;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/user_wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the timer slave.
// The slave modport is the arbiter's view; the master modport is its environment.
interface user_wb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [1:0]      m_cyc_i;
  logic [1:0]      m_stb_i;
  logic [1:0]      m_we_i;
  logic [2*SW-1:0] m_sel_i;
  logic [2*AW-1:0] m_adr_i;
  logic [2*DW-1:0] m_dat_i;
  logic [1:0]      m_ack_o;
  logic [1:0]      m_err_o;
  logic [DW-1:0]   m_dat_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [SW-1:0]   s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_ack_i;
  logic [DW-1:0]   s_dat_i;
  logic [1:0]      gnt_o;
  logic            to_irq_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
           s_dat_o, gnt_o, to_irq_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
           s_dat_o, gnt_o, to_irq_o
  );

endinterface

// File: rtl/user_wb_rr_pick.sv
// Two-input round-robin picker: on a tie the master that did not own last wins.
module user_wb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_i)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/user_wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC, with a
// stall watchdog that aborts the transfer via ERR and an interrupt pulse.
module user_wb_arbiter
  import user_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  user_wb_arbiter_if.slave  bus
);

  localparam int SW  = DW / 8;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e         state_q, state_d;
  logic           own_q, own_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [1:0]     req;
  logic [1:0]     pick;
  logic           own_cyc;
  logic           own_stb_raw;
  logic           timeout;

  assign req = bus.m_cyc_i & bus.m_stb_i;

  user_wb_rr_pick u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Everything toward the slave keys off the registered owner only.
  assign own_cyc     = (state_q == OWN) && bus.m_cyc_i[own_q];
  assign own_stb_raw = own_cyc && bus.m_stb_i[own_q];

  generate
    if (TIMEOUT > 0) begin : g_wd
      // An ACK in the expiry cycle still completes the transfer normally.
      assign timeout = own_stb_raw && !bus.s_ack_i && (wd_q == WDW'(TIMEOUT));
      always_comb begin
        wd_d = '0;
        if (own_stb_raw && !bus.s_ack_i && !timeout) begin
          wd_d = wd_q + WDW'(1);
        end
      end
    end else begin : g_no_wd
      assign timeout = 1'b0;
      assign wd_d    = '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          own_d   = pick[1];
        end
      end
      OWN: begin
        if (!bus.m_cyc_i[own_q]) begin
          state_d = IDLE;
          last_d  = own_q;
        end else if (timeout) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.m_cyc_i[own_q]) begin
          state_d = IDLE;
          last_d  = own_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_cyc_o        = own_cyc && !timeout;
    bus.s_stb_o        = own_stb_raw && !timeout;
    bus.s_we_o         = 1'b0;
    bus.s_sel_o        = '0;
    bus.s_adr_o        = '0;
    bus.s_dat_o        = '0;
    bus.m_ack_o        = 2'b00;
    bus.m_err_o        = 2'b00;
    bus.m_dat_o        = '0;
    bus.gnt_o          = 2'b00;
    bus.to_irq_o       = timeout;
    bus.m_ack_o[own_q] = own_cyc && bus.s_ack_i;
    bus.m_err_o[own_q] = timeout;
    if (state_q == OWN) begin
      bus.s_we_o  = bus.m_we_i[own_q];
      bus.s_sel_o = own_q ? bus.m_sel_i[2*SW-1:SW] : bus.m_sel_i[SW-1:0];
      bus.s_adr_o = own_q ? bus.m_adr_i[2*AW-1:AW] : bus.m_adr_i[AW-1:0];
      bus.s_dat_o = own_q ? bus.m_dat_i[2*DW-1:DW] : bus.m_dat_i[DW-1:0];
      bus.m_dat_o = bus.s_dat_i;
    end
    if (state_q != IDLE) begin
      bus.gnt_o = onehot2(own_q);
    end
  end

  // last_q resets to the LA master so the management bus wins the first tie.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_user_wb_arbiter.sv
// Bench for user_wb_arbiter: per-cycle vector table with expected outputs queued
// as stimulus is driven, plus a hand-written asynchronous-reset sequence.
module tb_user_wb_arbiter;
  import user_wb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  typedef struct packed {
    logic [1:0] gnt;
    logic       scyc;
    logic       sstb;
    logic [1:0] mack;
    logic [1:0] merr;
    logic       irq;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    obs_t       o;
  } vec_t;

  typedef struct packed {
    obs_t          o;
    logic [DW-1:0] rdat;
  } exp_t;

  logic wb_clk_i  = 1'b0;
  logic wb_rst_ni = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  user_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  user_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .bus       (bus.slave)
  );

  vec_t          vecs[$];
  string         names[$];
  exp_t          exp_q[$];
  logic [AW-1:0] adr_tab[2];
  logic [DW-1:0] wdat_tab[2];
  logic [SW-1:0] sel_tab[2];
  logic          we_tab[2];
  int            n_total = 0;
  int            n_pass  = 0;

  function automatic void add(input string n, input logic r, input logic [1:0] c,
                              input logic [1:0] s, input logic a, input logic [1:0] g,
                              input logic sc, input logic ss, input logic [1:0] ma,
                              input logic [1:0] me, input logic ir);
    vec_t v;
    v.rst    = r;
    v.cyc    = c;
    v.stb    = s;
    v.ack    = a;
    v.o.gnt  = g;
    v.o.scyc = sc;
    v.o.sstb = ss;
    v.o.mack = ma;
    v.o.merr = me;
    v.o.irq  = ir;
    vecs.push_back(v);
    names.push_back(n);
  endfunction

  task automatic check_zero(input string n);
    logic ok;
    ok = (bus.gnt_o == 2'b00) && !bus.s_cyc_o && !bus.s_stb_o && !bus.s_we_o &&
         (bus.s_sel_o == '0) && (bus.s_adr_o == '0) && (bus.s_dat_o == '0) &&
         (bus.m_ack_o == 2'b00) && (bus.m_err_o == 2'b00) && (bus.m_dat_o == '0) &&
         !bus.to_irq_o;
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: outputs not all zero gnt=%b cyc=%b stb=%b ack=%b err=%b irq=%b adr=%h",
                  n, bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o,
                  bus.to_irq_o, bus.s_adr_o);
  endtask

  task automatic do_reset();
    wb_rst_ni   = 1'b0;
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    bus.s_ack_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    check_zero("reset");
    wb_rst_ni = 1'b1;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic apply_vec(input vec_t v, input string n, input int idx);
    exp_t e;
    exp_t p;
    obs_t got;
    logic ok;
    int   own;
    bus.m_cyc_i = v.cyc;
    bus.m_stb_i = v.stb;
    bus.s_ack_i = v.ack;
    bus.s_dat_i = 32'hD000_0000 + 32'(idx);
    e.o    = v.o;
    e.rdat = bus.s_dat_i;
    exp_q.push_back(e);
    @(negedge wb_clk_i);
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s[%0d]: scoreboard empty", n, idx);
    end else begin
      p   = exp_q.pop_front();
      got = {bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o, bus.to_irq_o};
      ok  = (got == p.o);
      if (p.o.sstb) begin
        own = p.o.gnt[1] ? 1 : 0;
        ok  = ok && (bus.s_adr_o == adr_tab[own]) && (bus.s_dat_o == wdat_tab[own]) &&
              (bus.s_sel_o == sel_tab[own]) && (bus.s_we_o == we_tab[own]);
      end
      if (p.o.mack != 2'b00) ok = ok && (bus.m_dat_o == p.rdat);
      if (ok) n_pass++;
      else $display("FAIL %s[%0d]: got gnt=%b cyc=%b stb=%b ack=%b err=%b irq=%b adr=%h mdat=%h, want gnt=%b cyc=%b stb=%b ack=%b err=%b irq=%b mdat=%h",
                    n, idx, got.gnt, got.scyc, got.sstb, got.mack, got.merr, got.irq,
                    bus.s_adr_o, bus.m_dat_o, p.o.gnt, p.o.scyc, p.o.sstb, p.o.mack,
                    p.o.merr, p.o.irq, p.rdat);
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  initial begin
    adr_tab[0]  = 32'h3000_0004;  adr_tab[1]  = 32'h3000_0100;
    wdat_tab[0] = 32'hA5A5_0001;  wdat_tab[1] = 32'h5A5A_0002;
    sel_tab[0]  = 4'hF;           sel_tab[1]  = 4'h3;
    we_tab[0]   = 1'b1;           we_tab[1]   = 1'b0;
    bus.m_adr_i = {adr_tab[1], adr_tab[0]};
    bus.m_dat_i = {wdat_tab[1], wdat_tab[0]};
    bus.m_sel_i = {sel_tab[1], sel_tab[0]};
    bus.m_we_i  = {we_tab[1], we_tab[0]};
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;

    // Single M0 write: one cycle of arbitration, then passthrough.
    add("m0_write", 1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("m0_write", 0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("m0_write", 0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    add("m0_write", 0, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    add("m0_write", 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("m0_write", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Ties after reset: M0 first, then M1; waiting master never sees ACK.
    add("tie", 1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    add("tie", 0, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    add("tie", 0, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    add("tie", 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("tie", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    // M1 block of 4 reads with M0 pending.
    add("block", 0, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("block", 0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    add("block", 0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    add("block", 0, 2'b11, 2'b01, 0, 2'b10, 1, 0, 2'b00, 2'b00, 0);
    add("block", 0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    add("block", 0, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    add("block", 0, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0);
    add("block", 0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("block", 0, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    add("block", 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("block", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    // Hung slave: 8 stalled cycles, then ERR/IRQ and DRAIN until M0 drops CYC.
    add("timeout", 0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < TO; k++)
      add("timeout", 0, 2'b11, 2'b11, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    add("timeout", 0, 2'b11, 2'b11, 0, 2'b01, 0, 0, 2'b00, 2'b01, 1);
    add("timeout", 0, 2'b11, 2'b11, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("timeout", 0, 2'b11, 2'b11, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("timeout", 0, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("timeout", 0, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add("timeout", 0, 2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10, 2'b00, 0);
    add("timeout", 0, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0);
    add("timeout", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    // ACK exactly at the expiry count wins; a late ACK after CYC drop is ignored.
    add("ack_at_to", 0, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < TO; k++)
      add("ack_at_to", 0, 2'b01, 2'b01, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
    add("ack_at_to", 0, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 2'b00, 0);
    add("ack_at_to", 0, 2'b00, 2'b00, 1, 2'b01, 0, 0, 2'b00, 2'b00, 0);
    add("ack_at_to", 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      apply_vec(vecs[i], names[i], i);
    end

    // Asynchronous reset in the middle of an M1 transfer.
    begin
      vec_t v;
      v = '0;
      v.cyc = 2'b10; v.stb = 2'b10;
      apply_vec(v, "async_rst", 100);
      v.o.gnt = 2'b10; v.o.scyc = 1'b1; v.o.sstb = 1'b1;
      apply_vec(v, "async_rst", 101);
      #2;
      wb_rst_ni = 1'b0;
      #1;
      check_zero("async_rst_now");
      @(posedge wb_clk_i);
      #1;
      wb_rst_ni = 1'b1;
      v = '0;
      v.cyc = 2'b11; v.stb = 2'b11;
      apply_vec(v, "post_rst_tie", 102);
      v.ack = 1'b1;
      v.o.gnt = 2'b01; v.o.scyc = 1'b1; v.o.sstb = 1'b1; v.o.mack = 2'b01;
      apply_vec(v, "post_rst_tie", 103);
      v = '0;
      v.o.gnt = 2'b01;
      apply_vec(v, "post_rst_tie", 104);
      v.o.gnt = 2'b00;
      apply_vec(v, "post_rst_tie", 105);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
